// File: rtl/pe_diag_scheduler.sv
// Diagonal PE-array scheduler: filter load, per-column ifmap diagonal load, conv start/wait, per-row loop.
// Latency: Moore strobes; one cycle after start_i the first FILT/LOAD strobe appears; done_o one cycle after last out_valid_o.
// Backpressure: stall_i freezes sequencing and blanks strobes in the same cycle; abort_i returns to IDLE next cycle.
//
// Ports:
//   clk, nRST                      clock, async active-low reset
//   start_i, filt_reuse_i,
//   ifmap_w_i, num_rows_i          job request + config (sampled only in IDLE)
//   stall_i, abort_i               sequencing hold / job abort
//   PERead, PEStart, filtRead      one-hot / all-ones array strobes
//   out_valid_o, busy_o,
//   done_o, err_o                  status
module pe_diag_scheduler #(
  parameter int N_DIAG   = 5,
  parameter int N_FROW   = 3,
  parameter int K        = 3,
  parameter int CONV_LAT = 3
) (
  input  logic              clk,
  input  logic              nRST,
  input  logic              start_i,
  input  logic              filt_reuse_i,
  input  logic [7:0]        ifmap_w_i,
  input  logic [7:0]        num_rows_i,
  input  logic              stall_i,
  input  logic              abort_i,
  output logic [N_DIAG-1:0] PERead,
  output logic [N_DIAG-1:0] PEStart,
  output logic [N_FROW-1:0] filtRead,
  output logic              out_valid_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o
);

  localparam logic [7:0] K_W      = 8'(K);
  localparam logic [7:0] K_M1     = 8'(K - 1);
  localparam logic [7:0] NDIAG_M1 = 8'(N_DIAG - 1);
  localparam logic [7:0] NFROW_M1 = 8'(N_FROW - 1);
  localparam logic [7:0] LAT_M1   = 8'(CONV_LAT - 1);

  typedef enum logic [2:0] {S_IDLE, S_FILT, S_LOAD, S_START, S_WAIT, S_DONE} state_t;

  state_t     state, state_nxt;
  // sub: cycle within a step (filter column in FILT, diagonal in LOAD, latency tick in WAIT)
  logic [7:0] col, col_nxt, row, row_nxt, sub, sub_nxt, frow, frow_nxt;
  logic [7:0] cfg_w, cfg_w_nxt, cfg_rows, cfg_rows_nxt;
  logic       err_q, err_nxt;

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      state    <= S_IDLE;
      col      <= '0;
      row      <= '0;
      sub      <= '0;
      frow     <= '0;
      cfg_w    <= '0;
      cfg_rows <= '0;
      err_q    <= 1'b0;
    end else begin
      state    <= state_nxt;
      col      <= col_nxt;
      row      <= row_nxt;
      sub      <= sub_nxt;
      frow     <= frow_nxt;
      cfg_w    <= cfg_w_nxt;
      cfg_rows <= cfg_rows_nxt;
      err_q    <= err_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    col_nxt      = col;
    row_nxt      = row;
    sub_nxt      = sub;
    frow_nxt     = frow;
    cfg_w_nxt    = cfg_w;
    cfg_rows_nxt = cfg_rows;
    err_nxt      = 1'b0;

    case (state)
      S_IDLE: begin
        if (start_i) begin
          cfg_w_nxt    = ifmap_w_i;
          cfg_rows_nxt = num_rows_i;
          col_nxt      = '0;
          row_nxt      = '0;
          sub_nxt      = '0;
          frow_nxt     = '0;
          if (ifmap_w_i < K_W || num_rows_i == 8'd0) err_nxt = 1'b1;
          else state_nxt = filt_reuse_i ? S_LOAD : S_FILT;
        end
      end
      S_FILT: begin
        if (!stall_i) begin
          if (sub == K_M1) begin
            sub_nxt = '0;
            if (frow == NFROW_M1) begin
              frow_nxt  = '0;
              col_nxt   = '0;
              row_nxt   = '0;
              state_nxt = S_LOAD;
            end else begin
              frow_nxt = frow + 8'd1;
            end
          end else begin
            sub_nxt = sub + 8'd1;
          end
        end
      end
      S_LOAD: begin
        if (!stall_i) begin
          if (sub == NDIAG_M1) begin
            sub_nxt = '0;
            // The first K columns of a row are preloaded before the first start;
            // afterwards each column load is followed directly by a start.
            if (col < K_M1) col_nxt = col + 8'd1;
            else            state_nxt = S_START;
          end else begin
            sub_nxt = sub + 8'd1;
          end
        end
      end
      S_START: begin
        if (!stall_i) begin
          sub_nxt   = '0;
          state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (!stall_i) begin
          if (sub == LAT_M1) begin
            sub_nxt = '0;
            if (col < cfg_w - 8'd1) begin
              col_nxt   = col + 8'd1;
              state_nxt = S_LOAD;
            end else begin
              // row <= 254 here, so the increment cannot wrap
              col_nxt = '0;
              row_nxt = row + 8'd1;
              if (row + 8'd1 < cfg_rows) state_nxt = S_LOAD;
              else                       state_nxt = S_DONE;
            end
          end else begin
            sub_nxt = sub + 8'd1;
          end
        end
      end
      S_DONE: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase

    // Abort wins over stall and over any step completion.
    if (abort_i && state != S_IDLE) begin
      state_nxt = S_IDLE;
      col_nxt   = '0;
      row_nxt   = '0;
      sub_nxt   = '0;
      frow_nxt  = '0;
    end
  end

  always_comb begin
    PERead      = '0;
    PEStart     = '0;
    filtRead    = '0;
    out_valid_o = 1'b0;
    if (!stall_i) begin
      case (state)
        S_FILT:  filtRead    = N_FROW'(1) << frow;
        S_LOAD:  PERead      = N_DIAG'(1) << sub;
        S_START: PEStart     = '1;
        S_WAIT:  out_valid_o = (sub == LAT_M1);
        default: ;
      endcase
    end
  end

  assign busy_o = (state != S_IDLE);
  assign done_o = (state == S_DONE);
  assign err_o  = err_q;

endmodule

// File: tb/tb_pe_diag_scheduler.sv
// Bench for pe_diag_scheduler: per-cycle expected strobe traces queued per job and compared each cycle.
// Latency: none (testbench).
// Backpressure: drives stall_i/abort_i from per-job windows.
module tb_pe_diag_scheduler;

  localparam int ND = 5, NF = 3, KK = 3, LAT = 3;

  logic          clk = 1'b0;
  logic          nRST = 1'b0;
  logic          start_i = 1'b0, filt_reuse_i = 1'b0, stall_i = 1'b0, abort_i = 1'b0;
  logic [7:0]    ifmap_w_i = '0, num_rows_i = '0;
  logic [ND-1:0] PERead, PEStart;
  logic [NF-1:0] filtRead;
  logic          out_valid_o, busy_o, done_o, err_o;

  always #5 clk = ~clk;

  pe_diag_scheduler #(.N_DIAG(ND), .N_FROW(NF), .K(KK), .CONV_LAT(LAT)) dut (
    .clk(clk), .nRST(nRST), .start_i(start_i), .filt_reuse_i(filt_reuse_i),
    .ifmap_w_i(ifmap_w_i), .num_rows_i(num_rows_i), .stall_i(stall_i), .abort_i(abort_i),
    .PERead(PERead), .PEStart(PEStart), .filtRead(filtRead),
    .out_valid_o(out_valid_o), .busy_o(busy_o), .done_o(done_o), .err_o(err_o)
  );

  typedef struct packed {
    logic [4:0] pr;
    logic [4:0] ps;
    logic [2:0] fr;
    logic       ov;
    logic       busy;
    logic       done;
    logic       err;
  } obs_t;

  typedef struct {
    int   w;
    int   rows;
    logic reuse;
    int   exp_err;
    int   exp_nvalid;
  } vec_t;

  obs_t q_exp[$];
  int   n_cmp = 0, n_fail = 0;
  int   t_start, t_ov, t_done, t_idle;

  function automatic obs_t mk(logic [4:0] pr, logic [4:0] ps, logic [2:0] fr,
                              logic ov, logic busy, logic done, logic err);
    obs_t o;
    o.pr = pr; o.ps = ps; o.fr = fr; o.ov = ov; o.busy = busy; o.done = done; o.err = err;
    return o;
  endfunction

  function automatic obs_t sample();
    return mk(PERead, PEStart, filtRead, out_valid_o, busy_o, done_o, err_o);
  endfunction

  task automatic check_obs(input string name, input int cyc, input obs_t a, input obs_t e);
    n_cmp++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got pr=%b ps=%b fr=%b ov=%b busy=%b done=%b err=%b | want pr=%b ps=%b fr=%b ov=%b busy=%b done=%b err=%b",
               name, cyc, a.pr, a.ps, a.fr, a.ov, a.busy, a.done, a.err,
               e.pr, e.ps, e.fr, e.ov, e.busy, e.done, e.err);
    end
  endtask

  task automatic check_int(input string name, input int a, input int e);
    n_cmp++;
    if (a != e) begin
      n_fail++;
      $display("FAIL %s got=%0d want=%0d", name, a, e);
    end
  endtask

  // Expected per-cycle outputs of a job, starting the cycle after start_i is sampled.
  task automatic gen_job(input int w, input int rows, input logic reuse);
    logic [4:0] one5;
    logic [2:0] one3;
    one5 = 5'b00001;
    one3 = 3'b001;
    if (w < KK || rows == 0) begin
      q_exp.push_back(mk(5'b0, 5'b0, 3'b0, 1'b0, 1'b0, 1'b0, 1'b1));
      q_exp.push_back('0);
      return;
    end
    if (!reuse)
      for (int r = 0; r < NF; r++)
        for (int k = 0; k < KK; k++)
          q_exp.push_back(mk(5'b0, 5'b0, one3 << r, 1'b0, 1'b1, 1'b0, 1'b0));
    for (int rw = 0; rw < rows; rw++)
      for (int c = 0; c < w; c++) begin
        for (int d = 0; d < ND; d++)
          q_exp.push_back(mk(one5 << d, 5'b0, 3'b0, 1'b0, 1'b1, 1'b0, 1'b0));
        if (c >= KK - 1) begin
          q_exp.push_back(mk(5'b0, 5'b11111, 3'b0, 1'b0, 1'b1, 1'b0, 1'b0));
          for (int l = 0; l < LAT; l++)
            q_exp.push_back(mk(5'b0, 5'b0, 3'b0, (l == LAT - 1), 1'b1, 1'b0, 1'b0));
        end
      end
    q_exp.push_back(mk(5'b0, 5'b0, 3'b0, 1'b0, 1'b1, 1'b1, 1'b0));
    q_exp.push_back('0);
  endtask

  // Issues start_i, then pops and compares one expected record per cycle.
  // Windows are in cycle indices after the start edge (idx 0 = cycle 1).
  task automatic run_trace(input string name, input int w, input int rows, input logic reuse,
                           input int st_lo, input int st_hi, input int ab_at,
                           input int jk_lo, input int jk_hi,
                           output int nvalid, output int nerr);
    int   idx;
    obs_t a, e;
    nvalid = 0; nerr = 0;
    t_start = -1; t_ov = -1; t_done = -1; t_idle = -1;
    ifmap_w_i = 8'(w); num_rows_i = 8'(rows); filt_reuse_i = reuse; start_i = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    start_i = 1'b0;
    idx = 0;
    while (q_exp.size() > 0) begin
      stall_i = (idx >= st_lo && idx < st_hi);
      abort_i = (idx == ab_at);
      if (idx >= jk_lo && idx < jk_hi) begin
        start_i = 1'b1; ifmap_w_i = 8'd9; num_rows_i = 8'd7; filt_reuse_i = ~reuse;
      end else begin
        start_i = 1'b0;
      end
      @(negedge clk);
      a = sample();
      e = q_exp.pop_front();
      check_obs(name, idx + 1, a, e);
      if (a.ov) nvalid++;
      if (a.err) nerr++;
      if (a.ps != 5'b0 && t_start < 0) t_start = idx + 1;
      if (a.ov && t_ov < 0)            t_ov = idx + 1;
      if (a.done && t_done < 0)        t_done = idx + 1;
      if (!a.busy && t_idle < 0)       t_idle = idx + 1;
      @(posedge clk); #1;
      idx++;
    end
    stall_i = 1'b0; abort_i = 1'b0; start_i = 1'b0;
  endtask

  vec_t vecs[8];
  int   nv, ne;

  initial begin
    vecs[0] = '{3, 1, 1'b0, 0, 1};
    vecs[1] = '{5, 2, 1'b1, 0, 6};
    vecs[2] = '{2, 1, 1'b0, 1, 0};
    vecs[3] = '{4, 0, 1'b0, 1, 0};
    vecs[4] = '{3, 3, 1'b1, 0, 3};
    vecs[5] = '{6, 1, 1'b0, 0, 4};
    vecs[6] = '{3, 2, 1'b0, 0, 2};
    vecs[7] = '{4, 1, 1'b1, 0, 2};

    // Reset state, with a start request held during reset
    start_i = 1'b1; ifmap_w_i = 8'd3; num_rows_i = 8'd1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_obs("reset", 0, sample(), '0);
    start_i = 1'b0;
    nRST = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 8; i++) begin
      gen_job(vecs[i].w, vecs[i].rows, vecs[i].reuse);
      run_trace($sformatf("vec%0d", i), vecs[i].w, vecs[i].rows, vecs[i].reuse,
                -1, -1, -1, -1, -1, nv, ne);
      check_int($sformatf("vec%0d_nvalid", i), nv, vecs[i].exp_nvalid);
      check_int($sformatf("vec%0d_nerr", i), ne, vecs[i].exp_err);
      if (i == 0) begin
        check_int("t_pestart", t_start, 25);
        check_int("t_outvalid", t_ov, 28);
        check_int("t_done", t_done, 29);
        check_int("t_idle", t_idle, 30);
      end
    end

    // Stall 4 cycles in LOAD while PERead=00100
    gen_job(3, 1, 1'b1);
    for (int k = 0; k < 4; k++) q_exp.insert(2, mk(5'b0, 5'b0, 3'b0, 1'b0, 1'b1, 1'b0, 1'b0));
    run_trace("stall_load", 3, 1, 1'b1, 2, 6, -1, -1, -1, nv, ne);
    check_int("stall_load_nvalid", nv, 1);
    check_int("stall_load_done", t_done, 24);

    // Stall across the out_valid cycle in WAIT
    gen_job(3, 1, 1'b1);
    for (int k = 0; k < 2; k++) q_exp.insert(17, mk(5'b0, 5'b0, 3'b0, 1'b0, 1'b1, 1'b0, 1'b0));
    run_trace("stall_wait", 3, 1, 1'b1, 17, 19, -1, -1, -1, nv, ne);
    check_int("stall_wait_ov", t_ov, 21);

    // Abort (with simultaneous stall) on the first WAIT cycle
    gen_job(3, 1, 1'b1);
    while (q_exp.size() > 17) void'(q_exp.pop_back());
    repeat (3) q_exp.push_back('0);
    run_trace("abort", 3, 1, 1'b1, 16, 17, 16, -1, -1, nv, ne);
    check_int("abort_nvalid", nv, 0);
    check_int("abort_done", t_done, -1);

    // start_i and config churn while busy must not disturb the job
    gen_job(4, 1, 1'b1);
    run_trace("ignore_start", 4, 1, 1'b1, -1, -1, -1, 3, 8, nv, ne);
    check_int("ignore_start_nvalid", nv, 2);

    // Async reset in the middle of FILT
    ifmap_w_i = 8'd3; num_rows_i = 8'd1; filt_reuse_i = 1'b0; start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_obs("filt_mid", 3, sample(), mk(5'b0, 5'b0, 3'b001, 1'b0, 1'b1, 1'b0, 1'b0));
    nRST = 1'b0;
    #1;
    check_obs("rst_async", 3, sample(), '0);
    #1;
    nRST = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check_obs("rst_no_resume", 4 + k, sample(), '0);
    end
    @(posedge clk); #1;

    gen_job(3, 1, 1'b0);
    run_trace("after_rst", 3, 1, 1'b0, -1, -1, -1, -1, -1, nv, ne);
    check_int("after_rst_nvalid", nv, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
